// File: rtl/vec_uop_sequencer.sv
// Vector issue-stage sequencer: splits one LMUL-grouped instruction
// into a valid/ready stream of per-register micro-ops.
module vec_uop_sequencer #(
    parameter int VLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NREGS)-1:0] in_vs1,
    input  logic [$clog2(NREGS)-1:0] in_vs2,
    input  logic [$clog2(NREGS)-1:0] in_vd,
    input  logic [2:0]               in_op,
    input  logic [31:0]              in_scalar,
    input  logic [2:0]               in_sew,
    input  logic [2:0]               in_lmul,
    input  logic [8:0]               in_vl,
    output logic                     uop_valid,
    input  logic                     uop_ready,
    output logic [$clog2(NREGS)-1:0] uop_raA,
    output logic [$clog2(NREGS)-1:0] uop_raB,
    output logic [$clog2(NREGS)-1:0] uop_wa,
    output logic [2:0]               uop_op,
    output logic [31:0]              uop_scalar,
    output logic [2:0]               uop_sew,
    output logic [VLEN/8-1:0]        uop_byte_en,
    output logic [2:0]               uop_idx,
    output logic                     uop_first,
    output logic                     uop_last,
    output logic                     busy,
    output logic                     done,
    output logic                     illegal
);
    localparam int AW = $clog2(NREGS);
    localparam int BW = VLEN / 8;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] vs1_q, vs2_q, vd_q;
    logic [2:0]    op_q, sew_q, idx_q;
    logic [31:0]   scalar_q;
    logic [8:0]    rem_q;
    logic          done_q, illegal_q;

    // Decode of the offered instruction, used only on accept
    logic [3:0] in_epr;
    logic [6:0] vlmax;
    logic [2:0] grp_mask;
    logic       dec_illegal;

    always_comb begin
        in_epr   = 4'd8 >> in_sew[1:0];
        vlmax    = '0;
        grp_mask = '0;
        unique case (1'b1)
            !in_lmul[2]: begin
                vlmax    = 7'(in_epr) << in_lmul[1:0];
                grp_mask = 3'((4'd1 << in_lmul[1:0]) - 4'd1);
            end
            in_lmul == 3'b101: vlmax = 7'(in_epr >> 3);
            in_lmul == 3'b110: vlmax = 7'(in_epr >> 2);
            in_lmul == 3'b111: vlmax = 7'(in_epr >> 1);
            default:           vlmax = '0;
        endcase
        dec_illegal = in_sew[2]
                    | (in_lmul == 3'b100)
                    | (|((in_vs1[2:0] | in_vs2[2:0] | in_vd[2:0]) & grp_mask))
                    | (in_vl > {2'b00, vlmax});
    end

    logic          issuing;
    logic [3:0]    epr, act;
    logic [6:0]    nbytes;
    logic [BW:0]   be_mask;
    logic          last;

    always_comb begin
        issuing = (state == ISSUE);
        epr     = 4'd8 >> sew_q[1:0];
        act     = (rem_q <= 9'(epr)) ? rem_q[3:0] : epr;
        nbytes  = 7'(act) << sew_q[1:0];
        be_mask = ((BW+1)'(1) << nbytes) - (BW+1)'(1);
        last    = (rem_q <= 9'(epr));
    end

    assign in_ready    = !issuing;
    assign busy        = issuing;
    assign uop_valid   = issuing;
    assign done        = done_q;
    assign illegal     = illegal_q;
    // Data outputs read as zero whenever no micro-op is offered
    assign uop_raA     = issuing ? vs1_q + AW'(idx_q) : '0;
    assign uop_raB     = issuing ? vs2_q + AW'(idx_q) : '0;
    assign uop_wa      = issuing ? vd_q + AW'(idx_q)  : '0;
    assign uop_op      = issuing ? op_q     : '0;
    assign uop_scalar  = issuing ? scalar_q : '0;
    assign uop_sew     = issuing ? sew_q    : '0;
    assign uop_byte_en = issuing ? be_mask[BW-1:0] : '0;
    assign uop_idx     = issuing ? idx_q    : '0;
    assign uop_first   = issuing && (idx_q == 3'd0);
    assign uop_last    = issuing && last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vs1_q     <= '0;
            vs2_q     <= '0;
            vd_q      <= '0;
            op_q      <= '0;
            sew_q     <= '0;
            scalar_q  <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            if (state == IDLE) begin
                if (in_valid) begin
                    vs1_q    <= in_vs1;
                    vs2_q    <= in_vs2;
                    vd_q     <= in_vd;
                    op_q     <= in_op;
                    sew_q    <= in_sew;
                    scalar_q <= in_scalar;
                    rem_q    <= in_vl;
                    idx_q    <= '0;
                    if (dec_illegal)
                        illegal_q <= 1'b1;
                    else if (in_vl == 9'd0)
                        done_q <= 1'b1;
                    else
                        state <= ISSUE;
                end
            end else if (uop_ready) begin
                if (last) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                end else begin
                    idx_q <= idx_q + 3'd1;
                    rem_q <= rem_q - 9'(epr);
                end
            end
        end
    end
endmodule

// File: tb/tb_vec_uop_sequencer.sv
// Directed bench for vec_uop_sequencer with immediate-assertion checks.
module tb_vec_uop_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_vs1 = '0, in_vs2 = '0, in_vd = '0;
    logic [2:0]  in_op = '0;
    logic [31:0] in_scalar = '0;
    logic [2:0]  in_sew = '0, in_lmul = '0;
    logic [8:0]  in_vl = '0;
    logic        uop_valid;
    logic        uop_ready = 1'b1;
    logic [4:0]  uop_raA, uop_raB, uop_wa;
    logic [2:0]  uop_op, uop_sew, uop_idx;
    logic [31:0] uop_scalar;
    logic [7:0]  uop_byte_en;
    logic        uop_first, uop_last, busy, done, illegal;

    int total = 0;
    int passed = 0;

    vec_uop_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vs1(in_vs1), .in_vs2(in_vs2), .in_vd(in_vd),
        .in_op(in_op), .in_scalar(in_scalar),
        .in_sew(in_sew), .in_lmul(in_lmul), .in_vl(in_vl),
        .uop_valid(uop_valid), .uop_ready(uop_ready),
        .uop_raA(uop_raA), .uop_raB(uop_raB), .uop_wa(uop_wa),
        .uop_op(uop_op), .uop_scalar(uop_scalar), .uop_sew(uop_sew),
        .uop_byte_en(uop_byte_en), .uop_idx(uop_idx),
        .uop_first(uop_first), .uop_last(uop_last),
        .busy(busy), .done(done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [2:0] s,
                         input logic [2:0] l, input logic [8:0] v);
        in_valid = 1'b1;
        in_vs1 = a; in_vs2 = b; in_vd = d;
        in_sew = s; in_lmul = l; in_vl = v;
    endtask

    task automatic chk_uop(input string tag, input logic [4:0] ra,
                           input logic [4:0] rb, input logic [4:0] wa,
                           input logic [7:0] be, input logic [2:0] idx,
                           input logic fst, input logic lst);
        chk({tag, ".valid"}, 32'(uop_valid), 32'd1);
        chk({tag, ".raA"}, 32'(uop_raA), 32'(ra));
        chk({tag, ".raB"}, 32'(uop_raB), 32'(rb));
        chk({tag, ".wa"}, 32'(uop_wa), 32'(wa));
        chk({tag, ".be"}, 32'(uop_byte_en), 32'(be));
        chk({tag, ".idx"}, 32'(uop_idx), 32'(idx));
        chk({tag, ".first"}, 32'(uop_first), 32'(fst));
        chk({tag, ".last"}, 32'(uop_last), 32'(lst));
    endtask

    task automatic expect_pulse(input string tag, input logic d,
                                input logic il);
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".illegal"}, 32'(illegal), 32'(il));
        chk({tag, ".valid"}, 32'(uop_valid), 32'd0);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        tick();
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.valid", 32'(uop_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.be", 32'(uop_byte_en), 32'd0);
        chk("rst.first", 32'(uop_first), 32'd0);
        rst = 1'b0;
        tick();

        // SEW32 LMUL4 vl7: four uops, tail of one element
        in_op = 3'd5; in_scalar = 32'hDEADBEEF;
        offer(5'd8, 5'd12, 5'd4, 3'b010, 3'b010, 9'd7);
        tick(); in_valid = 1'b0;
        chk("a.busy", 32'(busy), 32'd1);
        chk("a.in_ready", 32'(in_ready), 32'd0);
        chk("a.op", 32'(uop_op), 32'd5);
        chk("a.scalar", uop_scalar, 32'hDEADBEEF);
        chk("a.sew", 32'(uop_sew), 32'd2);
        chk_uop("a0", 5'd8, 5'd12, 5'd4, 8'hFF, 3'd0, 1'b1, 1'b0);
        tick(); chk_uop("a1", 5'd9, 5'd13, 5'd5, 8'hFF, 3'd1, 1'b0, 1'b0);
        tick(); chk_uop("a2", 5'd10, 5'd14, 5'd6, 8'hFF, 3'd2, 1'b0, 1'b0);
        tick(); chk_uop("a3", 5'd11, 5'd15, 5'd7, 8'h0F, 3'd3, 1'b0, 1'b1);
        tick(); expect_pulse("a.end", 1'b1, 1'b0);
        tick(); chk("a.done_drop", 32'(done), 32'd0);

        // Same instruction with a 3-cycle stall at idx1
        offer(5'd8, 5'd12, 5'd4, 3'b010, 3'b010, 9'd7);
        tick(); in_valid = 1'b0;
        chk_uop("b0", 5'd8, 5'd12, 5'd4, 8'hFF, 3'd0, 1'b1, 1'b0);
        tick(); uop_ready = 1'b0;
        chk_uop("b1", 5'd9, 5'd13, 5'd5, 8'hFF, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_uop("b1hold", 5'd9, 5'd13, 5'd5, 8'hFF, 3'd1, 1'b0, 1'b0);
        end
        uop_ready = 1'b1;
        tick(); chk_uop("b2", 5'd10, 5'd14, 5'd6, 8'hFF, 3'd2, 1'b0, 1'b0);
        tick(); chk_uop("b3", 5'd11, 5'd15, 5'd7, 8'h0F, 3'd3, 1'b0, 1'b1);
        tick(); expect_pulse("b.end", 1'b1, 1'b0);

        // SEW8 LMUL1 vl3: single uop
        offer(5'd2, 5'd3, 5'd1, 3'b000, 3'b000, 9'd3);
        tick(); in_valid = 1'b0;
        chk_uop("c0", 5'd2, 5'd3, 5'd1, 8'h07, 3'd0, 1'b1, 1'b1);
        tick(); expect_pulse("c.end", 1'b1, 1'b0);

        // vl0: done only
        offer(5'd2, 5'd3, 5'd1, 3'b000, 3'b000, 9'd0);
        tick(); in_valid = 1'b0;
        expect_pulse("vl0", 1'b1, 1'b0);
        tick(); expect_pulse("vl0.after", 1'b0, 1'b0);

        // Illegal cases
        offer(5'd0, 5'd0, 5'd5, 3'b000, 3'b001, 9'd4);
        tick(); in_valid = 1'b0; expect_pulse("ill.align", 1'b0, 1'b1);
        tick(); expect_pulse("ill.align.after", 1'b0, 1'b0);
        offer(5'd0, 5'd0, 5'd0, 3'b011, 3'b000, 9'd2);
        tick(); in_valid = 1'b0; expect_pulse("ill.vlmax", 1'b0, 1'b1);
        tick();
        offer(5'd0, 5'd0, 5'd0, 3'b100, 3'b000, 9'd1);
        tick(); in_valid = 1'b0; expect_pulse("ill.sew", 1'b0, 1'b1);
        tick();
        offer(5'd0, 5'd0, 5'd0, 3'b000, 3'b100, 9'd1);
        tick(); in_valid = 1'b0; expect_pulse("ill.lmul", 1'b0, 1'b1);
        tick();
        offer(5'd0, 5'd0, 5'd0, 3'b000, 3'b111, 9'd5);
        tick(); in_valid = 1'b0; expect_pulse("ill.frac", 1'b0, 1'b1);
        tick();

        // Fractional LMUL 1/2 at SEW8: VLMAX 4, odd base register legal
        offer(5'd3, 5'd7, 5'd9, 3'b000, 3'b111, 9'd4);
        tick(); in_valid = 1'b0;
        chk_uop("frac0", 5'd3, 5'd7, 5'd9, 8'h0F, 3'd0, 1'b1, 1'b1);
        tick(); expect_pulse("frac.end", 1'b1, 1'b0);

        // SEW64 LMUL8 vl8 with a second instruction held on in_valid
        offer(5'd24, 5'd16, 5'd8, 3'b011, 3'b011, 9'd8);
        tick();
        offer(5'd1, 5'd2, 5'd3, 3'b000, 3'b000, 9'd3);
        for (int i = 0; i < 8; i++) begin
            chk_uop("d", 5'(24 + i), 5'(16 + i), 5'(8 + i), 8'hFF,
                    3'(i), i == 0, i == 7);
            chk("d.in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        chk("d.done", 32'(done), 32'd1);
        chk("d.in_ready_done", 32'(in_ready), 32'd1);
        chk("d.valid_done", 32'(uop_valid), 32'd0);
        tick(); in_valid = 1'b0;
        chk_uop("d2", 5'd1, 5'd2, 5'd3, 8'h07, 3'd0, 1'b1, 1'b1);
        chk("d2.done", 32'(done), 32'd0);
        tick(); expect_pulse("d2.end", 1'b1, 1'b0);

        // Asynchronous reset at idx2
        offer(5'd8, 5'd12, 5'd4, 3'b010, 3'b010, 9'd7);
        tick(); in_valid = 1'b0;
        tick(); tick();
        chk("e2.idx", 32'(uop_idx), 32'd2);
        rst = 1'b1;
        #1;
        chk("e.rst.valid", 32'(uop_valid), 32'd0);
        chk("e.rst.busy", 32'(busy), 32'd0);
        chk("e.rst.in_ready", 32'(in_ready), 32'd1);
        chk("e.rst.raA", 32'(uop_raA), 32'd0);
        chk("e.rst.be", 32'(uop_byte_en), 32'd0);
        tick();
        chk("e.rst.done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();
        chk("e.post.done", 32'(done), 32'd0);
        offer(5'd8, 5'd12, 5'd4, 3'b010, 3'b010, 9'd7);
        tick(); in_valid = 1'b0;
        chk_uop("f0", 5'd8, 5'd12, 5'd4, 8'hFF, 3'd0, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk_uop("f3", 5'd11, 5'd15, 5'd7, 8'h0F, 3'd3, 1'b0, 1'b1);
        tick(); expect_pulse("f.end", 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
